// File: rtl/dac_tx_pkg.sv
// Shared types and widths for the DAC serial transmit path.
package dac_tx_pkg;

    localparam int SAMPLE_W       = 32;
    localparam int UNDERRUN_CNT_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Saturating increment used by the underrun counter.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Single-clock first-word-fall-through sample buffer; pointers carry an extra
// wrap bit so full and empty are distinguishable.
module tx_word_fifo
    import dac_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  sample_t       i_din,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output sample_t       o_dout,
    output logic [AW:0]   o_level
);

    sample_t     r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    // Reset only moves the pointers; stale storage contents are unreachable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dac_output_tx.sv
// I2S / left-justified serial transmitter for the DAC data pin.
// Optional mute input is enabled by defining DAC_TX_MUTE_EN.
module dac_output_tx
    import dac_tx_pkg::*;
#(
    parameter bit I2S_MODE = 1'b0,
    parameter int DEPTH    = 4
) (
    input  logic                      bclk,
    input  logic                      resetn,
    input  logic                      sync,
    input  sample_t                   s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      sdata_out,
    output logic                      slot_left,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`ifdef DAC_TX_MUTE_EN
    ,
    input  logic                      mute
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic                      r_sync_d;
    logic                      r_armed;
    sample_t                   r_sr;
    logic                      r_s_ready;
    logic                      r_sdata;
    logic                      r_slot_left;
    logic                      r_ur_pend;
    logic                      r_underrun;
    logic [UNDERRUN_CNT_W-1:0] r_ur_cnt;

    logic        w_slot_start;
    logic        w_take;
    logic        w_push;
    logic        w_pop;
    logic        w_ur;
    logic        w_mute;
    logic        w_full;
    logic        w_empty;
    sample_t     w_dout;
    sample_t     w_new_word;
    logic [AW:0] w_level;
    logic [AW:0] w_level_next;

`ifdef DAC_TX_MUTE_EN
    assign w_mute = mute;
`else
    assign w_mute = 1'b0;
`endif

    assign w_slot_start = sync ^ r_sync_d;
    assign w_take       = w_slot_start && r_armed;
    assign w_pop        = w_take && !w_empty;
    assign w_ur         = w_take && w_empty;
    assign w_push       = s_valid && r_s_ready && !w_full;
    // A muted slot still pops so the stream keeps its alignment.
    assign w_new_word   = (w_pop && !w_mute) ? w_dout : '0;

    // s_ready is registered from the post-edge fill level so it drops on the
    // same edge that fills the last entry.
    assign w_level_next = w_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    tx_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (bclk),
        .i_rst_n (resetn),
        .i_push  (w_push),
        .i_din   (s_data),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_dout  (w_dout),
        .o_level (w_level)
    );

    always_ff @(posedge bclk or negedge resetn) begin
        if (!resetn) begin
            r_sync_d    <= 1'b0;
            r_armed     <= 1'b0;
            r_sr        <= '0;
            r_s_ready   <= 1'b0;
            r_sdata     <= 1'b0;
            r_slot_left <= 1'b0;
            r_ur_pend   <= 1'b0;
            r_underrun  <= 1'b0;
            r_ur_cnt    <= '0;
        end else begin
            r_sync_d   <= sync;
            r_s_ready  <= (w_level_next != FULL_LVL);
            r_ur_pend  <= w_ur;
            r_underrun <= r_ur_pend;
            if (r_ur_pend) r_ur_cnt <= sat_inc(r_ur_cnt);
            if (w_slot_start) r_armed <= 1'b1;
            if (w_take) r_slot_left <= !sync;

            if (!r_armed) begin
                r_sdata <= 1'b0;
                r_sr    <= '0;
            end else if (w_take) begin
                // I2S emits the leftover bit of the previous slot first.
                if (I2S_MODE) begin
                    r_sdata <= r_sr[SAMPLE_W-1];
                    r_sr    <= w_new_word;
                end else begin
                    r_sdata <= w_new_word[SAMPLE_W-1];
                    r_sr    <= {w_new_word[SAMPLE_W-2:0], 1'b0};
                end
            end else begin
                r_sdata <= r_sr[SAMPLE_W-1];
                r_sr    <= {r_sr[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    assign s_ready      = r_s_ready;
    assign sdata_out    = r_sdata;
    assign slot_left    = r_slot_left;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ur_cnt;

endmodule

// File: tb/tb_dac_output_tx.sv
// Bench for dac_output_tx: left-justified and I2S instances share one stimulus
// stream and are checked every bclk against a slot/offset scoreboard model.
module tb_dac_output_tx;
    import dac_tx_pkg::*;

    localparam int DEPTH = 4;

    logic        bclk    = 1'b0;
    logic        resetn  = 1'b0;
    logic        sync    = 1'b0;
    logic        s_valid = 1'b0;
    logic        mute    = 1'b0;
    logic [31:0] s_data  = '0;

    logic       lj_ready, lj_sd, lj_left, lj_ur;
    logic [7:0] lj_cnt;
    logic       is_ready, is_sd, is_left, is_ur;
    logic [7:0] is_cnt;

    always #5 bclk = ~bclk;

    dac_output_tx #(.I2S_MODE(1'b0), .DEPTH(DEPTH)) u_lj (
        .bclk         (bclk),
        .resetn       (resetn),
        .sync         (sync),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (lj_ready),
        .sdata_out    (lj_sd),
        .slot_left    (lj_left),
        .underrun     (lj_ur),
        .underrun_cnt (lj_cnt)
`ifdef DAC_TX_MUTE_EN
        ,
        .mute         (mute)
`endif
    );

    dac_output_tx #(.I2S_MODE(1'b1), .DEPTH(DEPTH)) u_i2s (
        .bclk         (bclk),
        .resetn       (resetn),
        .sync         (sync),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (is_ready),
        .sdata_out    (is_sd),
        .slot_left    (is_left),
        .underrun     (is_ur),
        .underrun_cnt (is_cnt)
`ifdef DAC_TX_MUTE_EN
        ,
        .mute         (mute)
`endif
    );

    // Scoreboard: words accepted by the handshake wait here for their slot.
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    logic        m_sync_d, m_armed, m_ready, m_left, m_ur, m_ur_pend;
    logic        m_sd_lj, m_sd_i2s;
    int          m_cnt, m_off;
    logic [31:0] m_w;

    function automatic logic lj_bit(input logic [31:0] w, input int n);
        return (n >= 0 && n < 32) ? w[31-n] : 1'b0;
    endfunction

    function automatic logic i2s_bit(input logic [31:0] w, input int n);
        return (n >= 1 && n <= 32) ? w[32-n] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_sync_d = 1'b0; m_armed = 1'b0; m_ready = 1'b0; m_left = 1'b0;
        m_ur = 1'b0; m_ur_pend = 1'b0; m_cnt = 0; m_off = 0; m_w = '0;
        m_sd_lj = 1'b0; m_sd_i2s = 1'b0;
    endtask

    // Advance the model across one posedge using the inputs currently driven.
    task automatic model_edge();
        logic        start;
        logic        mute_eff;
        logic        prev_rem;
        logic [31:0] nw;
`ifdef DAC_TX_MUTE_EN
        mute_eff = mute;
`else
        mute_eff = 1'b0;
`endif
        start = (sync != m_sync_d);
        m_ur  = m_ur_pend;
        if (m_ur_pend && m_cnt < 255) m_cnt++;
        m_ur_pend = 1'b0;
        if (start && m_armed) begin
            prev_rem = i2s_bit(m_w, m_off + 1);
            if (exp_q.size() > 0) begin
                nw = exp_q.pop_front();
                if (mute_eff) nw = '0;
            end else begin
                nw = '0;
                m_ur_pend = 1'b1;
            end
            m_w      = nw;
            m_off    = 0;
            m_left   = !sync;
            m_sd_lj  = lj_bit(m_w, 0);
            m_sd_i2s = prev_rem;
        end else begin
            if (m_off < 1000) m_off++;
            m_sd_lj  = lj_bit(m_w, m_off);
            m_sd_i2s = i2s_bit(m_w, m_off);
        end
        if (start) m_armed = 1'b1;
        if (s_valid && m_ready) exp_q.push_back(s_data);
        m_ready  = (exp_q.size() < DEPTH);
        m_sync_d = sync;
    endtask

    task automatic check_all();
        chk("sdata_lj",  {31'b0, lj_sd},    {31'b0, m_sd_lj});
        chk("sdata_i2s", {31'b0, is_sd},    {31'b0, m_sd_i2s});
        chk("left_lj",   {31'b0, lj_left},  {31'b0, m_left});
        chk("left_i2s",  {31'b0, is_left},  {31'b0, m_left});
        chk("ur_lj",     {31'b0, lj_ur},    {31'b0, m_ur});
        chk("ur_i2s",    {31'b0, is_ur},    {31'b0, m_ur});
        chk("cnt_lj",    {24'b0, lj_cnt},   32'(m_cnt));
        chk("cnt_i2s",   {24'b0, is_cnt},   32'(m_cnt));
        chk("ready_lj",  {31'b0, lj_ready}, {31'b0, m_ready});
        chk("ready_i2s", {31'b0, is_ready}, {31'b0, m_ready});
    endtask

    task automatic tick();
        if (resetn) model_edge();
        else        model_reset();
        @(posedge bclk);
        #1;
        check_all();
    endtask

    task automatic push_word(input logic [31:0] w);
        s_valid = 1'b1;
        s_data  = w;
        tick();
        s_valid = 1'b0;
    endtask

    // Toggle sync and hold it for len bclk; optionally push on the slot-start edge.
    task automatic run_slot(input int len, input logic push_at_start, input logic [31:0] w);
        sync = ~sync;
        if (push_at_start) begin
            s_valid = 1'b1;
            s_data  = w;
        end
        tick();
        s_valid = 1'b0;
        repeat (len - 1) tick();
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();

        // Two known words, arming slot, two data slots, then an empty slot.
        push_word(32'hA5A5_0001);
        push_word(32'h5A5A_8000);
        repeat (4) run_slot(32, 1'b0, '0);

        // Starved slots.
        repeat (3) run_slot(32, 1'b0, '0);

        // Back-to-back burst of six into a four-entry buffer.
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = $urandom();
            tick();
        end
        s_valid = 1'b0;
        repeat (2) tick();
        repeat (8) run_slot(32, 1'b0, '0);

        // Push on the same edge as a slot start with an empty buffer.
        run_slot(32, 1'b1, $urandom());
        run_slot(32, 1'b0, '0);

        // Short and long slots.
        for (int i = 0; i < 3; i++) push_word($urandom());
        run_slot(8, 1'b0, '0);
        run_slot(40, 1'b0, '0);
        run_slot(20, 1'b0, '0);
        run_slot(32, 1'b0, '0);

`ifdef DAC_TX_MUTE_EN
        push_word($urandom());
        push_word($urandom());
        mute = 1'b1;
        repeat (2) run_slot(32, 1'b0, '0);
        mute = 1'b0;
        push_word($urandom());
        run_slot(32, 1'b0, '0);
`endif

        // Reset at bit 10 of a slot while words are still buffered.
        push_word($urandom());
        push_word($urandom());
        run_slot(32, 1'b0, '0);
        sync = ~sync;
        repeat (10) tick();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) tick();
        resetn = 1'b1;
        repeat (20) tick();
        repeat (3) run_slot(32, 1'b0, '0);
        push_word($urandom());
        run_slot(32, 1'b0, '0);
        run_slot(32, 1'b0, '0);

        // Drive the underrun counter into saturation with two-bclk slots.
        repeat (262) run_slot(2, 1'b0, '0);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_output_tx.md
Name: dac_output_tx

Overview:
- I2S / left-justified serial transmitter driving the DAC data pin; mirror of the ADC capture path.
- Accepts 32-bit samples over a valid/ready handshake from the bclk-side end of the DAC clock-crossing FIFO.
- Buffers samples locally and shifts one word MSB-first per channel slot, aligned to the codec's frame sync.
- Flags underruns.

Parameters:
- I2S_MODE, 1'b0: 1 = I2S, with MSB delayed one bclk after the sync edge; 0 = left-justified, with MSB on the sync edge.
- DEPTH, 4: local word buffer entries; power of two, minimum 2.

Ports:
- bclk  input  1  bit clock, the only clock. All logic is on posedge.
- resetn  input  1  asynchronous active-low reset.
- sync  input  1  frame sync / word select from the codec; already bclk-synchronous.
- s_data  input  32  sample word, two's complement, MSB-first on the wire.
- s_valid  input  1  s_data valid.
- s_ready  output  1  buffer can accept a word.
- sdata_out  output  1  serial data to the DAC.
- slot_left  output  1  high while the current slot is the sync-low (left) slot.
- underrun  output  1  one-cycle pulse when a slot starts with the buffer empty.
- underrun_cnt  output  8  count of underrun pulses; saturates at 255.

Behaviour:
- Reset values (asynchronous):
  - sdata_out=0, s_ready=0, underrun=0, underrun_cnt=0, slot_left=0.
  - Buffer empty; shift register 0; sync_d=0; armed=0.
- s_ready = !buffer_full && resetn, registered. It becomes 1 on the first bclk after reset release.
- Write handshake: a word is accepted on any posedge where s_valid && s_ready.
- Edge detection: sync_d registers sync. Slot start at posedge k is sync != sync_d at that edge, so both polarities start a slot.
- The first slot start after reset sets armed=1. Until armed, sdata_out stays 0 and nothing is consumed.
- At each slot start once armed:
  - If the buffer is non-empty: pop one word into shift register sr.
  - If the buffer is empty: load sr=0, pulse underrun at posedge k+1, and increment underrun_cnt with saturation.
  - slot_left <= (sync==0).
- Serialization, left-justified (I2S_MODE=0):
  - sdata_out <= new word bit31 at posedge k.
  - Bit 31-n is driven at posedge k+n.
- Serialization, I2S (I2S_MODE=1):
  - At posedge k, sdata_out <= the bit remaining from the previous slot, i.e. the previous LSB when slots are 32 bclk.
  - Bit31 is driven at posedge k+1; bit 31-n at posedge k+1+n.
- Short slots (fewer than 32 bclk): undriven low bits are dropped; the next slot starts normally.
- Long slots: zeros are shifted after the LSB.
- Simultaneous push and pop on the same edge:
  - Both occur.
  - A pop on an empty buffer with a same-cycle push is still an underrun; the pushed word stays for the next slot.
- Push while full cannot happen because s_ready=0. Pop while empty is the underrun path above.
- Pointers wrap modulo DEPTH. An extra wrap bit distinguishes full from empty.
- Reset asserted mid-slot: everything returns to reset values immediately; buffered words are discarded; re-arming waits for the next sync edge.

Optional Feature:
- DAC_TX_MUTE_EN defined:
  - Adds input mute (1 bit).
  - mute is sampled at slot start. When it is 1, sr loads 0 but a buffered word is still popped, so the stream stays in sync.
  - Underrun detection is unchanged.
- DAC_TX_MUTE_EN not defined: no mute port; behaviour as above.

Decomposition:
- Package dac_tx_pkg:
  - SAMPLE_W=32
  - typedef logic [SAMPLE_W-1:0] sample_t
  - UNDERRUN_CNT_W=8
- Sub-module tx_word_fifo: single-clock FIFO of DEPTH entries with push, pop, full, empty and dout (first-word-fall-through).
- dac_output_tx holds the edge detect, arming, shift register, underrun logic and optional mute.

Test Plan:
1. I2S_MODE=0, push 32'hA5A5_0001 and 32'h5A5A_8000, sync toggling every 32 bclk -> sdata_out carries bit31 at the edge cycle; 64 bits match MSB-first; slot_left tracks sync==0.
2. I2S_MODE=1, same words -> every bit is delayed one bclk relative to test 1; the LSB of word 0 appears on the first bclk of slot 2.
3. No words pushed, armed, 3 slot starts -> three one-cycle underrun pulses; underrun_cnt=3; sdata_out all 0.
4. DEPTH=4, push 6 words back-to-back with no slots -> s_ready drops after the 4th accept; 8 slots later, 4 words, then 4 underruns, then underrun_cnt=4.
5. Assert resetn=0 at bit 10 of a slot, release after 3 bclk -> sdata_out=0 immediately; pre-reset words are never transmitted; output resumes only after the next sync edge.
6. DAC_TX_MUTE_EN defined, mute=1 for 2 slots with 2 words buffered -> sdata_out 0; both words consumed; underrun_cnt=0.
